frame_pixel_streamer: RTL and testbench
=======================================

// Module: frame_pixel_streamer
// PURPOSE
//  Reads one stored frame from a synchronous frame-buffer RAM in raster order and emits it as
//  a pixel stream (data/valid plus position and framing flags) into the windowing line buffers
//  of the flow pipeline. Supports downstream backpressure and configurable horizontal blanking.
//  One start pulse streams one full frame.
// PARAMETERS
//  WIDTH       320  pixels per line
//  HEIGHT      240  lines per frame
//  DATA_WIDTH  12   signed pixel width
//  HBLANK      0    idle cycles inserted between the last read of a line and the first read of the next
// PORTS
//  clk         in   1                           clock, all logic on rising edge
//  rst         in   1                           synchronous, active-high reset
//  start       in   1                           frame request, sampled only in IDLE
//  busy        out  1                           high from accepted start until done
//  done        out  1                           1-cycle pulse after last pixel handshake
//  rd_en       out  1                           RAM read enable
//  rd_addr     out  $clog2(WIDTH*HEIGHT)        RAM word address, y*WIDTH+x
//  rd_data     in   DATA_WIDTH (signed)         RAM data, valid exactly 1 cycle after rd_en
//  data_out    out  DATA_WIDTH (signed)         pixel
//  data_valid  out  1                           pixel valid
//  data_ready  in   1                           downstream accept; transfer = data_valid && data_ready
//  sof         out  1                           high with pixel (0,0)
//  eol         out  1                           high with any pixel x=WIDTH-1
//  out_x       out  $clog2(WIDTH)               column of data_out
//  out_y       out  $clog2(HEIGHT)              row of data_out
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; skid and in-flight read discarded. Reset
//   mid-frame aborts immediately, no done pulse; a RAM word returning the cycle after is ignored.
//  FSM: IDLE -> READ on start. READ issues reads; after read of x=WIDTH-1: if last line -> DRAIN,
//   else HBLANK (HBLANK>0) or stay READ. HBLANK counts HBLANK cycles, no reads, -> READ.
//   DRAIN waits until no read in flight and no buffered pixel, then -> IDLE, pulsing done.
//  start while busy is ignored; start held high in IDLE after done launches the next frame
//   (one IDLE cycle minimum between frames).
//  Address: incremented counter (no multiplier), 0..WIDTH*HEIGHT-1, reset to 0 per frame.
//  Read-side coordinates (rx,ry) travel with each read; out_x/out_y/sof/eol derive from them.
//  Buffering: output register + one skid entry. Invariant: reads in flight + occupied entries
//   <= 2, so a returning word always has a slot; no pixel is ever dropped or duplicated.
//  Handshake: while data_valid && !data_ready, data_out/out_x/out_y/sof/eol held stable.
//   data_valid never drops without a transfer. Skid drains before newer data (order preserved).
//  Latency: start sampled cycle 0 -> rd_en cycle 1 (addr 0) -> data_valid cycle 2 (pixel 0,0).
//  Throughput: 1 pixel/clk with data_ready high and HBLANK=0; with HBLANK=N and ready high,
//   exactly N invalid cycles between eol pixel and next line's x=0 pixel.
//  done: asserted the cycle after transfer of (WIDTH-1,HEIGHT-1); busy falls same cycle.
//  rd_en low whenever state is IDLE, HBLANK or DRAIN, or the invariant would be violated.
//  Widths: rd_addr increment saturation-free; last address WIDTH*HEIGHT-1 must fit.
// TESTING
//  W=4,H=3,HBLANK=0, RAM[i]=i, ready=1, start@c0 -> rd_en c1..c12 addr 0..11; data_out 0..11 on
//   c2..c13 contiguous; sof c2 only; eol with 3,7,11; done c14; busy c1..c13.
//  Same frame, data_ready pseudo-random 50% -> received sequence exactly 0..11, out_x/out_y
//   match i%4, i/4, outputs never change while stalled; never more than 2 reads outstanding.
//  HBLANK=3, ready=1 -> exactly 3 idle data_valid cycles after pixels 3 and 7, none after 11.
//  rst high after pixel 5 transfers -> next cycle all outputs 0, no done; new start streams from
//   pixel 0 correctly.
//  start pulsed at pixel 6 of an active frame -> ignored, single done; start held high ->
//   two back-to-back frames, each 0..11, two done pulses.
//  data_ready=0 from c2 for 10 cycles -> pixel 0 held, rd_en stops after addr 1; release ->
//   pixels 0,1,2... with no loss.

Source files
------------

// File: rtl/frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_pixel_streamer
// Description : Streams one stored frame from a synchronous frame-buffer RAM
//               in raster order as a valid/ready pixel stream with position
//               and framing flags. Optional horizontal blanking between lines.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pixel_streamer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int DATA_WIDTH = 12,
    parameter int HBLANK     = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rd_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]       rd_addr,
    input  logic signed [DATA_WIDTH-1:0]          rd_data,
    output logic signed [DATA_WIDTH-1:0]          data_out,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic                                  sof,
    output logic                                  eol,
    output logic [$clog2(WIDTH)-1:0]              out_x,
    output logic [$clog2(HEIGHT)-1:0]             out_y
);

    localparam int c_ADDR_W = $clog2(WIDTH*HEIGHT);
    localparam int c_X_W    = $clog2(WIDTH);
    localparam int c_Y_W    = $clog2(HEIGHT);
    localparam int c_HB_W   = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [c_X_W-1:0]  c_X_LAST  = c_X_W'(WIDTH - 1);
    localparam logic [c_Y_W-1:0]  c_Y_LAST  = c_Y_W'(HEIGHT - 1);
    localparam logic [c_HB_W-1:0] c_HB_LAST = c_HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_READ   = 2'd1;
    localparam logic [1:0] c_S_HBLANK = 2'd2;
    localparam logic [1:0] c_S_DRAIN  = 2'd3;

    // Control / read side
    logic [1:0]            r_state;
    logic [c_ADDR_W-1:0]   r_addr;
    logic [c_X_W-1:0]      r_rx;
    logic [c_Y_W-1:0]      r_ry;
    logic [c_HB_W-1:0]     r_hb_cnt;
    logic                  r_busy;
    logic                  r_done;

    // Read in flight: RAM word is on rd_data this cycle
    logic                  r_inf;
    logic [c_X_W-1:0]      r_if_x;
    logic [c_Y_W-1:0]      r_if_y;

    // Output register (head of queue)
    logic                         r_ov;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic [c_X_W-1:0]             r_out_x;
    logic [c_Y_W-1:0]             r_out_y;

    // Skid entry (only occupied while the output register is occupied)
    logic                         r_sv;
    logic signed [DATA_WIDTH-1:0] r_sk_data;
    logic [c_X_W-1:0]             r_sk_x;
    logic [c_Y_W-1:0]             r_sk_y;

    logic [1:0] w_occ;
    logic       w_issue;
    logic       w_xfer;
    logic       w_empty_next;

    logic                         w_ov_n;
    logic signed [DATA_WIDTH-1:0] w_out_data_n;
    logic [c_X_W-1:0]             w_out_x_n;
    logic [c_Y_W-1:0]             w_out_y_n;
    logic                         w_sv_n;
    logic signed [DATA_WIDTH-1:0] w_sk_data_n;
    logic [c_X_W-1:0]             w_sk_x_n;
    logic [c_Y_W-1:0]             w_sk_y_n;

    // Reads in flight plus held pixels; a new read is only issued when at
    // most one slot is used, so the returning word always finds room.
    assign w_occ        = 2'(r_ov) + 2'(r_sv) + 2'(r_inf);
    assign w_issue      = (r_state == c_S_READ) && (w_occ <= 2'd1);
    assign w_xfer       = data_valid && data_ready;
    assign w_empty_next = (w_occ == {1'b0, w_xfer});

    // A returning word with an empty output register is presented directly,
    // giving a pixel the cycle after its read.
    assign data_valid = r_ov | r_inf;
    assign data_out   = r_ov ? r_out_data : (r_inf ? rd_data : '0);
    assign out_x      = r_ov ? r_out_x    : (r_inf ? r_if_x  : '0);
    assign out_y      = r_ov ? r_out_y    : (r_inf ? r_if_y  : '0);
    assign sof        = data_valid && (out_x == '0) && (out_y == '0);
    assign eol        = data_valid && (out_x == c_X_LAST);

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = w_issue;
    assign rd_addr = r_addr;

    // Next contents of output register and skid: pop head on transfer, then
    // compact remaining entries oldest-first (output, skid, returning word).
    always_comb begin
        w_ov_n       = r_ov;
        w_out_data_n = r_out_data;
        w_out_x_n    = r_out_x;
        w_out_y_n    = r_out_y;
        w_sv_n       = r_sv;
        w_sk_data_n  = r_sk_data;
        w_sk_x_n     = r_sk_x;
        w_sk_y_n     = r_sk_y;
        if (r_ov) begin
            if (w_xfer) begin
                if (r_sv) begin
                    w_out_data_n = r_sk_data;
                    w_out_x_n    = r_sk_x;
                    w_out_y_n    = r_sk_y;
                    w_sv_n       = r_inf;
                    w_sk_data_n  = rd_data;
                    w_sk_x_n     = r_if_x;
                    w_sk_y_n     = r_if_y;
                end else begin
                    w_ov_n       = r_inf;
                    w_out_data_n = rd_data;
                    w_out_x_n    = r_if_x;
                    w_out_y_n    = r_if_y;
                    w_sv_n       = 1'b0;
                end
            end else if (!r_sv && r_inf) begin
                w_sv_n      = 1'b1;
                w_sk_data_n = rd_data;
                w_sk_x_n    = r_if_x;
                w_sk_y_n    = r_if_y;
            end
        end else begin
            w_ov_n       = r_inf && !w_xfer;
            w_out_data_n = rd_data;
            w_out_x_n    = r_if_x;
            w_out_y_n    = r_if_y;
            w_sv_n       = 1'b0;
        end
    end

    // Pixel buffering: in-flight tracking, output register and skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inf      <= 1'b0;
            r_if_x     <= '0;
            r_if_y     <= '0;
            r_ov       <= 1'b0;
            r_out_data <= '0;
            r_out_x    <= '0;
            r_out_y    <= '0;
            r_sv       <= 1'b0;
            r_sk_data  <= '0;
            r_sk_x     <= '0;
            r_sk_y     <= '0;
        end else begin
            r_inf      <= w_issue;
            r_if_x     <= r_rx;
            r_if_y     <= r_ry;
            r_ov       <= w_ov_n;
            r_out_data <= w_out_data_n;
            r_out_x    <= w_out_x_n;
            r_out_y    <= w_out_y_n;
            r_sv       <= w_sv_n;
            r_sk_data  <= w_sk_data_n;
            r_sk_x     <= w_sk_x_n;
            r_sk_y     <= w_sk_y_n;
        end
    end

    // Frame sequencing FSM with read address / raster coordinate counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_addr   <= '0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_hb_cnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                r_addr <= r_addr + c_ADDR_W'(1);
                if (r_rx == c_X_LAST) begin
                    r_rx <= '0;
                    r_ry <= r_ry + c_Y_W'(1);
                end else begin
                    r_rx <= r_rx + c_X_W'(1);
                end
            end
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_READ;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_rx    <= '0;
                        r_ry    <= '0;
                    end
                end
                c_S_READ: begin
                    if (w_issue && (r_rx == c_X_LAST)) begin
                        if (r_ry == c_Y_LAST) begin
                            r_state <= c_S_DRAIN;
                        end else if (HBLANK > 0) begin
                            r_state  <= c_S_HBLANK;
                            r_hb_cnt <= '0;
                        end
                    end
                end
                c_S_HBLANK: begin
                    if (r_hb_cnt == c_HB_LAST) begin
                        r_state <= c_S_READ;
                    end else begin
                        r_hb_cnt <= r_hb_cnt + c_HB_W'(1);
                    end
                end
                c_S_DRAIN: begin
                    if (w_empty_next) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_pixel_streamer
// Description : Directed self-checking bench for frame_pixel_streamer on a
//               4x3 frame, with and without horizontal blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start_h, data_ready;

    logic               busy, done, rd_en, data_valid, sof, eol;
    logic [3:0]         rd_addr;
    logic signed [11:0] rd_data, data_out;
    logic [1:0]         out_x, out_y;

    logic               busy_h, done_h, rd_en_h, data_valid_h, sof_h, eol_h;
    logic [3:0]         rd_addr_h;
    logic signed [11:0] rd_data_h, data_out_h;
    logic [1:0]         out_x_h, out_y_h;

    logic signed [11:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    frame_pixel_streamer #(.WIDTH(4), .HEIGHT(3), .DATA_WIDTH(12), .HBLANK(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .sof(sof), .eol(eol), .out_x(out_x), .out_y(out_y)
    );

    frame_pixel_streamer #(.WIDTH(4), .HEIGHT(3), .DATA_WIDTH(12), .HBLANK(3)) u_dut_h (
        .clk(clk), .rst(rst), .start(start_h), .busy(busy_h), .done(done_h),
        .rd_en(rd_en_h), .rd_addr(rd_addr_h), .rd_data(rd_data_h),
        .data_out(data_out_h), .data_valid(data_valid_h), .data_ready(data_ready),
        .sof(sof_h), .eol(eol_h), .out_x(out_x_h), .out_y(out_y_h)
    );

    // Synchronous RAM models: word valid the cycle after the read enable.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    always @(posedge clk) if (rd_en_h) rd_data_h <= mem[rd_addr_h];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_h = 1'b0; data_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, rd_en, data_valid, sof, eol} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, rd_en, data_valid, sof, eol});
        end
        checks++;
        if ({rd_addr, data_out, out_x, out_y} !== 20'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%0d data=%0d x=%0d y=%0d exp all 0", rd_addr, data_out, out_x, out_y);
        end
        checks++;
        if ({busy_h, done_h, rd_en_h, data_valid_h, sof_h, eol_h} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags_hb got=%b exp=000000", {busy_h, done_h, rd_en_h, data_valid_h, sof_h, eol_h});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int  idx;
        logic exp_rd, exp_v;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            exp_rd = (c >= 1) && (c <= 12);
            exp_v  = (c >= 2) && (c <= 13);
            idx    = c - 2;
            checks++;
            if (rd_en !== exp_rd || (exp_rd && rd_addr !== 4'(c - 1))) begin
                errors++;
                $display("FAIL basic_rd c%0d got en=%b addr=%0d exp en=%b addr=%0d", c, rd_en, rd_addr, exp_rd, c - 1);
            end
            checks++;
            if (data_valid !== exp_v || (exp_v && (data_out !== 12'(idx) || out_x !== 2'(idx % 4) || out_y !== 2'(idx / 4)))) begin
                errors++;
                $display("FAIL basic_pix c%0d got v=%b d=%0d x=%0d y=%0d exp v=%b d=%0d", c, data_valid, data_out, out_x, out_y, exp_v, idx);
            end
            checks++;
            if (sof !== (c == 2) || eol !== (exp_v && (idx % 4 == 3))) begin
                errors++;
                $display("FAIL basic_flags c%0d got sof=%b eol=%b", c, sof, eol);
            end
            checks++;
            if (done !== (c == 14) || busy !== ((c >= 1) && (c <= 13))) begin
                errors++;
                $display("FAIL basic_done c%0d got done=%b busy=%b exp done=%b busy=%b", c, done, busy, (c == 14), ((c >= 1) && (c <= 13)));
            end
            tick();
        end
    endtask

    task automatic test_random_ready();
        int idx = 0, issued = 0;
        logic seen_done = 1'b0;
        logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
        logic signed [11:0] pd = '0;
        logic [1:0] px = '0, py = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            data_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                checks++;
                if (!data_valid || data_out !== pd || out_x !== px || out_y !== py || sof !== ps || eol !== pe) begin
                    errors++;
                    $display("FAIL rand_hold got v=%b d=%0d x=%0d y=%0d exp d=%0d x=%0d y=%0d", data_valid, data_out, out_x, out_y, pd, px, py);
                end
            end
            checks++;
            if (issued - idx > 2) begin
                errors++;
                $display("FAIL rand_outstanding got %0d exp <=2", issued - idx);
            end
            if (data_valid && data_ready) begin
                checks++;
                if (data_out !== 12'(idx) || out_x !== 2'(idx % 4) || out_y !== 2'(idx / 4) || sof !== (idx == 0) || eol !== (idx % 4 == 3)) begin
                    errors++;
                    $display("FAIL rand_pix got d=%0d x=%0d y=%0d sof=%b eol=%b exp d=%0d", data_out, out_x, out_y, sof, eol, idx);
                end
                idx++;
            end
            if (done) seen_done = 1'b1;
            if (rd_en) issued++;
            pv = data_valid; pr = data_ready; pd = data_out;
            px = out_x; py = out_y; ps = sof; pe = eol;
            tick();
        end
        data_ready = 1'b1;
        checks++;
        if (!seen_done || idx != 12) begin
            errors++;
            $display("FAIL rand_count got pixels=%0d done=%b exp pixels=12 done=1", idx, seen_done);
        end
    endtask

    task automatic test_hblank();
        int idx = 0, gap = 0;
        logic seen_done = 1'b0;
        data_ready = 1'b1;
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
            if (done_h) begin
                seen_done = 1'b1;
                checks++;
                if (idx != 12 || gap != 0) begin
                    errors++;
                    $display("FAIL hb_done got pixels=%0d gap=%0d exp pixels=12 gap=0", idx, gap);
                end
            end else if (data_valid_h) begin
                checks++;
                if (data_out_h !== 12'(idx) || gap != (((idx == 4) || (idx == 8)) ? 3 : 0)) begin
                    errors++;
                    $display("FAIL hb_pix got d=%0d gap=%0d exp d=%0d gap=%0d", data_out_h, gap, idx, ((idx == 4) || (idx == 8)) ? 3 : 0);
                end
                idx++;
                gap = 0;
            end else if (idx > 0) begin
                gap++;
            end
            tick();
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL hb_timeout got done=0 exp done=1");
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        logic hit = 1'b0, seen_done = 1'b0, bad = 1'b0;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            if (data_valid && data_out == 12'sd5) hit = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (!hit || {busy, done, rd_en, data_valid, sof, eol} !== 6'b0 || {rd_addr, data_out, out_x, out_y} !== 20'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got hit=%b flags=%b d=%0d addr=%0d exp hit=1 all 0", hit,
                     {busy, done, rd_en, data_valid, sof, eol}, data_out, rd_addr);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (done || busy || data_valid) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstmid_quiet got activity after reset exp none");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            if (data_valid) begin
                checks++;
                if (data_out !== 12'(idx) || out_x !== 2'(idx % 4) || out_y !== 2'(idx / 4)) begin
                    errors++;
                    $display("FAIL rstmid_pix got d=%0d x=%0d y=%0d exp d=%0d", data_out, out_x, out_y, idx);
                end
                idx++;
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (!seen_done || idx != 12) begin
            errors++;
            $display("FAIL rstmid_count got pixels=%0d done=%b exp 12/1", idx, seen_done);
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            start = (data_valid && data_out == 12'sd6);
            if (done) ndone++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (ndone != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored got done_pulses=%0d busy=%b exp 1/0", ndone, busy);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0, ndone = 0, done_cyc = 0;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 80 && ndone < 2; cyc++) begin
            if (data_valid) begin
                checks++;
                if (data_out !== 12'(idx % 12) || out_x !== 2'(idx % 4) || out_y !== 2'((idx % 12) / 4)) begin
                    errors++;
                    $display("FAIL b2b_pix got d=%0d x=%0d y=%0d exp d=%0d", data_out, out_x, out_y, idx % 12);
                end
                if (idx == 12) begin
                    checks++;
                    if (cyc != done_cyc + 2) begin
                        errors++;
                        $display("FAIL b2b_gap got first pixel %0d cycles after done exp 2", cyc - done_cyc);
                    end
                end
                idx++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (ndone == 1 && busy) start = 1'b0;
            tick();
        end
        start = 1'b0;
        checks++;
        if (ndone != 2 || idx != 24) begin
            errors++;
            $display("FAIL b2b_count got done=%0d pixels=%0d exp 2/24", ndone, idx);
        end
        repeat (3) tick();
    endtask

    task automatic test_stall();
        int nrd = 0, idx = 0;
        logic [3:0] last_addr = '0;
        logic seen_done = 1'b0;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (rd_en) begin nrd++; last_addr = rd_addr; end
        tick();
        data_ready = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            checks++;
            if (!data_valid || data_out !== 12'sd0 || !sof) begin
                errors++;
                $display("FAIL stall_hold c%0d got v=%b d=%0d sof=%b exp v=1 d=0 sof=1", c, data_valid, data_out, sof);
            end
            if (rd_en) begin nrd++; last_addr = rd_addr; end
            tick();
        end
        checks++;
        if (nrd != 2 || last_addr !== 4'd1) begin
            errors++;
            $display("FAIL stall_reads got reads=%0d last_addr=%0d exp 2/1", nrd, last_addr);
        end
        data_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            if (data_valid) begin
                checks++;
                if (data_out !== 12'(idx) || out_x !== 2'(idx % 4) || out_y !== 2'(idx / 4)) begin
                    errors++;
                    $display("FAIL stall_pix got d=%0d x=%0d y=%0d exp d=%0d", data_out, out_x, out_y, idx);
                end
                idx++;
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (!seen_done || idx != 12) begin
            errors++;
            $display("FAIL stall_count got pixels=%0d done=%b exp 12/1", idx, seen_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 12'(i);
        rd_data   = '0;
        rd_data_h = '0;
        test_reset();
        test_basic();
        test_random_ready();
        test_hblank();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
